// File: rtl/univ_shift_reg_oe.sv
// rtl/univ_shift_reg_oe.sv - WIDTH-bit universal shift register with serial burst engine and tri-stated outputs
//
// Purpose:
//    Parallel load, logical shift and rotate in both directions, synchronous
//    clear, and an automatic WIDTH-cycle serial-transfer burst. The register
//    value is presented in true and inverted form on tri-stated buses, and
//    the LSB is always available as a serial output.
//
// Ports:
//    CLK   in   1      rising-edge clock
//    CLR   in   1      asynchronous active-low reset
//    OE    in   1      output enable for Q/QN (0 -> high impedance)
//    MODE  in   3      operation select, sampled on each rising CLK edge
//    D     in   WIDTH  parallel load data
//    SIR   in   1      serial input for shift right (enters at MSB)
//    SIL   in   1      serial input for shift left (enters at LSB)
//    Q     out  WIDTH  register value, or Z when OE=0
//    QN    out  WIDTH  inverted register value, or Z when OE=0
//    SO    out  1      serial output, register bit 0 (never tri-stated)
//    BUSY  out  1      high while a burst is in progress
//    DONE  out  1      one-cycle pulse after the final burst shift

module univ_shift_reg_oe #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               CNT_W     = 4
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             OE,
   input  logic [2:0]       MODE,
   input  logic [WIDTH-1:0] D,
   input  logic             SIR,
   input  logic             SIL,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] QN,
   output logic             SO,
   output logic             BUSY,
   output logic             DONE
);

   localparam logic [2:0] MODE_HOLD  = 3'b000;
   localparam logic [2:0] MODE_SHR   = 3'b001;
   localparam logic [2:0] MODE_SHL   = 3'b010;
   localparam logic [2:0] MODE_LOAD  = 3'b011;
   localparam logic [2:0] MODE_ROR   = 3'b100;
   localparam logic [2:0] MODE_ROL   = 3'b101;
   localparam logic [2:0] MODE_CLEAR = 3'b110;
   localparam logic [2:0] MODE_BURST = 3'b111;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shift_q;
   logic [CNT_W-1:0] cnt;

   // Shift-right value shared by MODE=001 and every burst edge.
   logic [WIDTH-1:0] shr_val;
   assign shr_val = {SIR, shift_q[WIDTH-1:1]};

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         shift_q <= RESET_VAL;
         state   <= ST_IDLE;
         cnt     <= '0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            ST_IDLE: begin
               case (MODE)
                  MODE_HOLD:  shift_q <= shift_q;
                  MODE_SHR:   shift_q <= shr_val;
                  MODE_SHL:   shift_q <= {shift_q[WIDTH-2:0], SIL};
                  MODE_LOAD:  shift_q <= D;
                  MODE_ROR:   shift_q <= {shift_q[0], shift_q[WIDTH-1:1]};
                  MODE_ROL:   shift_q <= {shift_q[WIDTH-2:0], shift_q[WIDTH-1]};
                  MODE_CLEAR: shift_q <= '0;
                  MODE_BURST: begin
                     // The start edge already performs the first shift.
                     shift_q <= shr_val;
                     cnt     <= CNT_ONE;
                     BUSY    <= 1'b1;
                     state   <= ST_BURST;
                  end
                  default:    shift_q <= shift_q;
               endcase
            end

            ST_BURST: begin
               shift_q <= shr_val;
               if (cnt == CNT_LAST) begin
                  DONE <= 1'b1;
                  cnt  <= '0;
                  // Burst mode still requested at the final shift: chain
                  // straight into the next burst so BUSY never drops. The
                  // counter restarts at zero because no shift of the new
                  // burst has happened yet.
                  if (MODE != MODE_BURST) begin
                     state <= ST_IDLE;
                     BUSY  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            default: begin
               state <= ST_IDLE;
               BUSY  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign SO = shift_q[0];
   assign Q  = OE ? shift_q  : {WIDTH{1'bz}};
   assign QN = OE ? ~shift_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_univ_shift_reg_oe.sv
// tb/tb_univ_shift_reg_oe.sv - directed table-driven bench for univ_shift_reg_oe

module tb_univ_shift_reg_oe;

   logic       clk;
   logic       clr;
   logic       oe;
   logic [2:0] mode;
   logic [7:0] d;
   logic       sir;
   logic       sil;
   wire  [7:0] q;
   wire  [7:0] qn;
   wire        so;
   wire        busy;
   wire        done;

   int checks   = 0;
   int failures = 0;

   univ_shift_reg_oe #(
      .WIDTH     (8),
      .RESET_VAL (8'h00),
      .CNT_W     (4)
   ) dut (
      .CLK  (clk),
      .CLR  (clr),
      .OE   (oe),
      .MODE (mode),
      .D    (d),
      .SIR  (sir),
      .SIL  (sil),
      .Q    (q),
      .QN   (qn),
      .SO   (so),
      .BUSY (busy),
      .DONE (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [2:0] mode;
      logic [7:0] d;
      logic       sir;
      logic       sil;
      logic       oe;
      logic [7:0] exp_q;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One rising edge, then settle away from it before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] val);
      mode = 3'b011;
      d    = val;
      step();
      chk("load_q", {24'd0, q}, {24'd0, val});
      mode = 3'b000;
   endtask

   // Burst of the 8'h96 pattern with SIR=0; mid_mode is driven on every
   // edge after the start to show that MODE is ignored during BURST.
   task automatic run_burst(input string tag, input logic [2:0] mid_mode, input logic [7:0] mid_d);
      logic [7:0] pattern;
      pattern = 8'h96;
      load(pattern);
      sir  = 1'b0;
      mode = 3'b111;
      chk({tag, "_so0"}, {31'd0, so}, {31'd0, pattern[0]});
      step();
      mode = mid_mode;
      d    = mid_d;
      chk({tag, "_busy1"}, {31'd0, busy}, 32'd1);
      for (int k = 1; k < 8; k++) begin
         chk({tag, "_so"}, {31'd0, so}, {31'd0, pattern[k]});
         chk({tag, "_done_lo"}, {31'd0, done}, 32'd0);
         step();
         if (k < 7) chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      end
      chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done_hi"}, {31'd0, done}, 32'd1);
      chk({tag, "_final_q"}, {24'd0, q}, 32'h00);
      mode = 3'b000;
      step();
      chk({tag, "_done_clr"}, {31'd0, done}, 32'd0);
   endtask

   vec_t vecs[11];

   initial begin
      vecs[0]  = '{mode: 3'b011, d: 8'hA5, sir: 1'b0, sil: 1'b0, oe: 1'b1, exp_q: 8'hA5};
      vecs[1]  = '{mode: 3'b000, d: 8'h00, sir: 1'b0, sil: 1'b0, oe: 1'b0, exp_q: 8'hA5};
      vecs[2]  = '{mode: 3'b000, d: 8'h00, sir: 1'b0, sil: 1'b0, oe: 1'b1, exp_q: 8'hA5};
      vecs[3]  = '{mode: 3'b001, d: 8'h00, sir: 1'b1, sil: 1'b0, oe: 1'b1, exp_q: 8'hD2};
      vecs[4]  = '{mode: 3'b010, d: 8'h00, sir: 1'b0, sil: 1'b0, oe: 1'b1, exp_q: 8'hA4};
      vecs[5]  = '{mode: 3'b100, d: 8'h00, sir: 1'b0, sil: 1'b0, oe: 1'b1, exp_q: 8'h52};
      vecs[6]  = '{mode: 3'b101, d: 8'h00, sir: 1'b0, sil: 1'b0, oe: 1'b1, exp_q: 8'hA4};
      vecs[7]  = '{mode: 3'b010, d: 8'h00, sir: 1'b0, sil: 1'b1, oe: 1'b1, exp_q: 8'h49};
      vecs[8]  = '{mode: 3'b001, d: 8'h00, sir: 1'b0, sil: 1'b0, oe: 1'b1, exp_q: 8'h24};
      vecs[9]  = '{mode: 3'b011, d: 8'h3C, sir: 1'b0, sil: 1'b0, oe: 1'b1, exp_q: 8'h3C};
      vecs[10] = '{mode: 3'b110, d: 8'h00, sir: 1'b0, sil: 1'b0, oe: 1'b1, exp_q: 8'h00};

      clr  = 1'b0;
      oe   = 1'b1;
      mode = 3'b000;
      d    = 8'h00;
      sir  = 1'b0;
      sil  = 1'b0;
      #1;
      chk("reset_q", {24'd0, q}, 32'h00);
      chk("reset_qn", {24'd0, qn}, 32'hFF);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      step();
      clr = 1'b1;
      step();
      chk("post_reset_q", {24'd0, q}, 32'h00);

      // Register operations and output enable.
      for (int i = 0; i < 11; i++) begin
         mode = vecs[i].mode;
         d    = vecs[i].d;
         sir  = vecs[i].sir;
         sil  = vecs[i].sil;
         oe   = vecs[i].oe;
         step();
         if (vecs[i].oe) begin
            chk($sformatf("vec%0d_q", i), {24'd0, q}, {24'd0, vecs[i].exp_q});
            chk($sformatf("vec%0d_qn", i), {24'd0, qn}, {24'd0, ~vecs[i].exp_q});
         end else begin
            // Driven outputs are always complementary, so equal buses mean
            // neither is driven.
            chk($sformatf("vec%0d_hiz", i), {31'd0, (q === qn)}, 32'd1);
         end
         chk($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
      end
      mode = 3'b000;
      oe   = 1'b1;

      run_burst("burst", 3'b000, 8'h00);
      run_burst("burst_ign", 3'b011, 8'hFF);

      // Asynchronous reset mid-burst, counter at 3.
      load(8'h96);
      sir  = 1'b0;
      mode = 3'b111;
      step();
      mode = 3'b000;
      step();
      step();
      chk("abort_busy_pre", {31'd0, busy}, 32'd1);
      #2;
      clr = 1'b0;
      #1;
      chk("abort_q", {24'd0, q}, 32'h00);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("abort_done_rst", {31'd0, done}, 32'd0);
      end
      clr = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("abort_done_idle", {31'd0, done}, 32'd0);
         chk("abort_busy_idle", {31'd0, busy}, 32'd0);
      end
      load(8'h5C);

      // Clear, then back-to-back bursts with MODE=111 held for 17 edges.
      load(8'h3C);
      mode = 3'b110;
      step();
      chk("clear_q", {24'd0, q}, 32'h00);
      chk("clear_qn", {24'd0, qn}, 32'hFF);
      sir  = 1'b1;
      mode = 3'b111;
      for (int e = 1; e <= 17; e++) begin
         step();
         chk($sformatf("chain_busy_e%0d", e), {31'd0, busy}, 32'd1);
         chk($sformatf("chain_done_e%0d", e), {31'd0, done}, {31'd0, (e == 8 || e == 16)});
         if (e == 8) chk("chain_q_e8", {24'd0, q}, 32'hFF);
      end
      mode = 3'b000;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg_oe.md
Name: univ_shift_reg_oe

Overview:
- Parametrised successor to the team's fixed 4-bit clear/output-enable register.
- WIDTH-bit universal register with:
  - parallel load, logical shift and rotate in both directions, synchronous clear;
  - an automatic serial-transfer burst (state machine with BUSY/DONE);
  - tri-stated true and inverted outputs.
- Sits between board-level data buses and serial peripherals in lab designs; the registered value is readable in parallel or streamed out serially.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- RESET_VAL, 0, value loaded into the register on asynchronous reset.
- CNT_W, 4, width of the burst bit counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  input  1  rising-edge clock.
- CLR  input  1  asynchronous, active-low reset.
- OE  input  1  output enable, active-high. 0 drives Q and QN to high impedance.
- MODE  input  3  operation select, sampled on each rising CLK edge.
- D  input  WIDTH  parallel load data.
- SIR  input  1  serial input for shift right; enters at the MSB.
- SIL  input  1  serial input for shift left; enters at the LSB.
- Q  output  WIDTH  register value when OE=1, else Z.
- QN  output  WIDTH  bitwise inverse of the register value when OE=1, else Z.
- SO  output  1  serial out, equal to reg[0]. Not tri-stated.
- BUSY  output  1  high while a burst is in progress.
- DONE  output  1  one-cycle pulse after the final burst shift.

Behaviour:
- Reset (CLR=0, asynchronous, overrides everything):
  - reg=RESET_VAL, state=IDLE, counter=0, BUSY=0, DONE=0.
  - Q/QN still follow OE combinationally.
- MODE decode in IDLE; each operation takes effect on the rising edge:
  - 000 hold.
  - 001 shift right: reg={SIR, reg[WIDTH-1:1]}.
  - 010 shift left: reg={reg[WIDTH-2:0], SIL}.
  - 011 parallel load: reg=D.
  - 100 rotate right: reg={reg[0], reg[WIDTH-1:1]}.
  - 101 rotate left: reg={reg[WIDTH-2:0], reg[WIDTH-1]}.
  - 110 synchronous clear: reg=0.
  - 111 burst start.
- State machine, states IDLE and BURST:
  - IDLE to BURST on MODE=111. That same edge performs the first shift right (SIR in) and sets counter=1 and BUSY=1.
  - In BURST:
    - Every edge shifts right with SIR in and increments the counter. MODE is ignored.
    - On the edge where counter==WIDTH-1 (the WIDTH-th shift), go to IDLE with BUSY=0, DONE=1.
    - DONE clears on the next edge.
  - A burst takes exactly WIDTH cycles. SO presents original bit k during cycle k, k=0..WIDTH-1.
  - MODE=111 held after completion starts a new burst on the next edge. DONE and the new BUSY are then both high for that one cycle.
- Output enable:
  - OE acts combinationally, with no clock involvement. Toggling OE never changes register contents.
  - QN is always exactly ~Q whenever OE=1.
- Reset mid-burst aborts immediately. No DONE pulse is produced.
- DONE never asserts except after a completed burst.

Test Plan:
1. WIDTH=8, release CLR, OE=1, MODE=011, D=8'hA5, one edge -> Q=8'hA5, QN=8'h5A. Set OE=0 -> Q=QN=Z. Set OE=1 -> Q=8'hA5 restored.
2. From 8'hA5:
   - MODE=001, SIR=1, one edge -> Q=8'hD2.
   - Then MODE=010, SIL=0 -> Q=8'hA4.
   - Then MODE=100 -> Q=8'h52.
   - Then MODE=101 -> Q=8'hA4.
3. Load 8'h96, then MODE=111 for one edge, then MODE=000, SIR=0:
   - BUSY high for exactly 8 cycles;
   - SO sequence 0,1,1,0,1,0,0,1;
   - DONE pulses once, one cycle long, after the 8th shift;
   - final Q=8'h00.
4. During a burst, drive MODE=011 with D=8'hFF -> ignored; burst completes normally with the same SO sequence.
5. Assert CLR=0 asynchronously mid-burst at counter=3 -> Q=RESET_VAL immediately, BUSY=0, DONE never pulses. After release, MODE=011 loads normally.
6. Load 8'h3C, then MODE=110 -> Q=8'h00, QN=8'hFF. Hold MODE=111 continuously for 17 edges -> two back-to-back bursts, two DONE pulses, BUSY low for 0 cycles between bursts.
